// File: rtl/rv_pkg.sv
// Shared RV32I opcode constants, ID-stage FSM states and the default bubble word.
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HAZ   = 2'd1,
    ST_FLUSH = 2'd2
  } id_state_t;

endpackage

// File: rtl/inst_decode_stage_if.sv
// Fetch-to-decode bus: instruction handshake in, stall back, decoded fields out.
interface inst_decode_stage_if;
  logic [31:0] inst_in;
  logic        inst_valid;
  logic        branch_taken;
  logic        stall_out;
  logic [24:0] Inst;
  logic        ILoad;
  logic        S;
  logic        SB;
  logic        U;
  logic        UJ;
  logic        nop;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;

  // Fetch side / environment
  modport master (
    output inst_in, inst_valid, branch_taken,
    input  stall_out, Inst, ILoad, S, SB, U, UJ, nop, rs1, rs2, rd
  );

  // Decode stage
  modport slave (
    input  inst_in, inst_valid, branch_taken,
    output stall_out, Inst, ILoad, S, SB, U, UJ, nop, rs1, rs2, rd
  );
endinterface

// File: rtl/opcode_type_decode.sv
// Pure opcode classifier: immediate-type selects and register-source usage flags.
module opcode_type_decode
  import rv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       iload_o,
  output logic       s_o,
  output logic       sb_o,
  output logic       u_o,
  output logic       uj_o,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o
);

  // Opcode lookup; R-type and unknown opcodes assert no immediate select
  always_comb begin
    iload_o    = 1'b0;
    s_o        = 1'b0;
    sb_o       = 1'b0;
    u_o        = 1'b0;
    uj_o       = 1'b0;
    uses_rs1_o = 1'b0;
    uses_rs2_o = 1'b0;
    case (opcode_i)
      OP_LOAD, OP_IMM, OP_JALR: begin
        iload_o    = 1'b1;
        uses_rs1_o = 1'b1;
      end
      OP_STORE: begin
        s_o        = 1'b1;
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b1;
      end
      OP_BRANCH: begin
        sb_o       = 1'b1;
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b1;
      end
      OP_LUI, OP_AUIPC: u_o = 1'b1;
      OP_JAL:           uj_o = 1'b1;
      OP_R: begin
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_decode_stage.sv
// IF/ID register with immediate-type decode, load-use stall and branch flush bubbles.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | normal capture; load-use hazard and branch are checked here
//   ST_HAZ   | one bubble issued for load-use; capture the held inst_in
//   ST_FLUSH | issuing the remaining branch-flush bubbles, inst_in ignored
module inst_decode_stage
  import rv_pkg::*;
#(
  parameter int unsigned FLUSH_BUBBLES = 2,
  parameter logic [31:0] NOP_WORD      = NOP_WORD_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  inst_decode_stage_if.slave bus
);

  localparam logic [2:0] CNT_RELOAD = 3'(FLUSH_BUBBLES - 1);

  id_state_t   state_q, state_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        stall;

  logic id_iload, id_s, id_sb, id_u, id_uj, id_use1, id_use2;
  logic in_iload, in_s, in_sb, in_u, in_uj, in_use1, in_use2;
  logic hazard;

  opcode_type_decode u_dec_id (
    .opcode_i   (id_inst_q[6:0]),
    .iload_o    (id_iload),
    .s_o        (id_s),
    .sb_o       (id_sb),
    .u_o        (id_u),
    .uj_o       (id_uj),
    .uses_rs1_o (id_use1),
    .uses_rs2_o (id_use2)
  );

  opcode_type_decode u_dec_in (
    .opcode_i   (bus.inst_in[6:0]),
    .iload_o    (in_iload),
    .s_o        (in_s),
    .sb_o       (in_sb),
    .u_o        (in_u),
    .uj_o       (in_uj),
    .uses_rs1_o (in_use1),
    .uses_rs2_o (in_use2)
  );

  // Only the usage flags of the incoming word and the selects of the ID word matter
  logic unused_dec;
  assign unused_dec = ^{in_iload, in_s, in_sb, in_u, in_uj, id_use1, id_use2};

  // Load in ID whose destination is read by the instruction waiting in fetch
  always_comb begin
    hazard = 1'b0;
    if (id_valid_q && (id_inst_q[6:0] == OP_LOAD) && (id_inst_q[11:7] != 5'd0) &&
        bus.inst_valid) begin
      hazard = (in_use1 && (bus.inst_in[19:15] == id_inst_q[11:7])) ||
               (in_use2 && (bus.inst_in[24:20] == id_inst_q[11:7]));
    end
  end

  // Next-state logic: branch flush beats hazard, hazard beats normal capture
  always_comb begin
    state_d    = state_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    cnt_d      = cnt_q;
    stall      = 1'b0;
    case (state_q)
      ST_RUN, ST_HAZ: begin
        if (bus.branch_taken) begin
          id_inst_d  = NOP_WORD;
          id_valid_d = 1'b0;
          if (FLUSH_BUBBLES > 1) begin
            cnt_d   = CNT_RELOAD;
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end else if ((state_q == ST_RUN) && hazard) begin
          stall      = 1'b1;
          id_inst_d  = NOP_WORD;
          id_valid_d = 1'b0;
          state_d    = ST_HAZ;
        end else begin
          id_inst_d  = bus.inst_in;
          id_valid_d = bus.inst_valid;
          state_d    = ST_RUN;
        end
      end
      ST_FLUSH: begin
        id_inst_d  = NOP_WORD;
        id_valid_d = 1'b0;
        if (bus.branch_taken) begin
          cnt_d = CNT_RELOAD;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        id_inst_d  = NOP_WORD;
        id_valid_d = 1'b0;
        cnt_d      = 3'd0;
        state_d    = ST_RUN;
      end
    endcase
  end

  // ID register, valid flag, FSM state and bubble counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      id_inst_q  <= NOP_WORD;
      id_valid_q <= 1'b0;
      cnt_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.stall_out = stall;
  assign bus.Inst      = id_inst_q[31:7];
  assign bus.ILoad     = id_valid_q & id_iload;
  assign bus.S         = id_valid_q & id_s;
  assign bus.SB        = id_valid_q & id_sb;
  assign bus.U         = id_valid_q & id_u;
  assign bus.UJ        = id_valid_q & id_uj;
  assign bus.nop       = ~id_valid_q;
  assign bus.rs1       = id_inst_q[19:15];
  assign bus.rs2       = id_inst_q[24:20];
  assign bus.rd        = id_inst_q[11:7];

endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed bench for inst_decode_stage with a cycle model and per-cycle comparison.
module tb_inst_decode_stage;

  localparam int unsigned FB  = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  inst_decode_stage_if bus();

  inst_decode_stage #(.FLUSH_BUBBLES(FB), .NOP_WORD(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the ID slot holds, pending flush bubbles, and whether the
  // previous cycle was a load-use stall (next one captures unconditionally).
  logic [31:0] m_inst;
  logic        m_valid;
  int          m_flush_left;
  bit          m_held;

  function automatic logic [4:0] sel_of(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: return 5'b10000;
      7'b0100011:                         return 5'b01000;
      7'b1100011:                         return 5'b00100;
      7'b0110111, 7'b0010111:             return 5'b00010;
      7'b1101111:                         return 5'b00001;
      default:                            return 5'b00000;
    endcase
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011, 7'b0110011};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {7'b0100011, 7'b1100011, 7'b0110011};
  endfunction

  function automatic bit model_stall();
    logic [4:0] dst;
    dst = m_inst[11:7];
    if (rst || bus.branch_taken || m_flush_left != 0 || m_held) return 1'b0;
    if (!m_valid || m_inst[6:0] != 7'b0000011 || dst == 5'd0 || !bus.inst_valid) return 1'b0;
    return (reads_rs1(bus.inst_in[6:0]) && bus.inst_in[19:15] == dst) ||
           (reads_rs2(bus.inst_in[6:0]) && bus.inst_in[24:20] == dst);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_inst = NOP; m_valid = 1'b0; m_flush_left = 0; m_held = 1'b0;
    end else if (bus.branch_taken) begin
      m_inst = NOP; m_valid = 1'b0; m_flush_left = FB - 1; m_held = 1'b0;
    end else if (m_flush_left > 0) begin
      m_inst = NOP; m_valid = 1'b0; m_flush_left--;
    end else if (model_stall()) begin
      m_inst = NOP; m_valid = 1'b0; m_held = 1'b1;
    end else begin
      m_inst = bus.inst_in; m_valid = bus.inst_valid; m_held = 1'b0;
    end
  end

  // Per-cycle comparison against the model, mid-cycle with inputs stable
  always @(negedge clk) begin
    chk("stall_out", {31'd0, bus.stall_out}, {31'd0, model_stall()});
    chk("Inst", {7'd0, bus.Inst}, {7'd0, m_inst[31:7]});
    chk("selects", {27'd0, bus.ILoad, bus.S, bus.SB, bus.U, bus.UJ},
        {27'd0, m_valid ? sel_of(m_inst[6:0]) : 5'b00000});
    chk("nop", {31'd0, bus.nop}, {31'd0, ~m_valid});
    chk("regs", {17'd0, bus.rs1, bus.rs2, bus.rd},
        {17'd0, m_inst[19:15], m_inst[24:20], m_inst[11:7]});
  end

  task automatic drive(input logic [31:0] inst, input logic valid, input logic br);
    bus.inst_in      = inst;
    bus.inst_valid   = valid;
    bus.branch_taken = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sel_now();
    return {27'd0, bus.ILoad, bus.S, bus.SB, bus.U, bus.UJ};
  endfunction

  initial begin
    drive(32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_nop", {31'd0, bus.nop}, 32'd1);
    chk("rst_inst", {7'd0, bus.Inst}, 32'd0);
    chk("rst_sel", sel_now(), 32'd0);
    chk("rst_stall", {31'd0, bus.stall_out}, 32'd0);
    rst = 1'b0;

    drive(32'h00500093, 1'b1, 1'b0); tick();
    chk("addi_iload", sel_now(), 32'h10);
    chk("addi_inst", {7'd0, bus.Inst}, 32'h0000A001);
    chk("addi_rd", {27'd0, bus.rd}, 32'd1);
    chk("addi_nop", {31'd0, bus.nop}, 32'd0);

    drive(32'h00112023, 1'b1, 1'b0); tick(); chk("sw_S", sel_now(), 32'h08);
    drive(32'h00208463, 1'b1, 1'b0); tick(); chk("beq_SB", sel_now(), 32'h04);
    drive(32'h123450B7, 1'b1, 1'b0); tick(); chk("lui_U", sel_now(), 32'h02);
    drive(32'h008000EF, 1'b1, 1'b0); tick(); chk("jal_UJ", sel_now(), 32'h01);

    drive(32'h0, 1'b0, 1'b0); tick();
    chk("invalid_nop", {31'd0, bus.nop}, 32'd1);

    // load-use: lw x5 then add x6,x5,x2
    drive(32'h0000A283, 1'b1, 1'b0); tick();
    drive(32'h00228333, 1'b1, 1'b0); #1;
    chk("lu_stall", {31'd0, bus.stall_out}, 32'd1);
    tick();
    chk("lu_bubble", {31'd0, bus.nop}, 32'd1);
    chk("lu_stall_off", {31'd0, bus.stall_out}, 32'd0);
    tick();
    chk("lu_add_sel", sel_now(), 32'd0);
    chk("lu_add_rs1", {27'd0, bus.rs1}, 32'd5);
    chk("lu_add_nop", {31'd0, bus.nop}, 32'd0);

    // branch flush: two bubbles, inst_in ignored meanwhile
    drive(32'h00500093, 1'b1, 1'b1); tick();
    chk("br_nop1", {31'd0, bus.nop}, 32'd1);
    drive(32'h00A00113, 1'b1, 1'b0); tick();
    chk("br_nop2", {31'd0, bus.nop}, 32'd1);
    tick();
    chk("br_resume", {31'd0, bus.nop}, 32'd0);
    chk("br_resume_rd", {27'd0, bus.rd}, 32'd2);

    // lw x0 followed by a use of x0: no stall
    drive(32'h0000A003, 1'b1, 1'b0); tick();
    drive(32'h00000333, 1'b1, 1'b0); #1;
    chk("x0_nostall", {31'd0, bus.stall_out}, 32'd0);
    tick();

    // hazard and branch together: branch wins
    drive(32'h0000A283, 1'b1, 1'b0); tick();
    drive(32'h00228333, 1'b1, 1'b1); #1;
    chk("hb_stall", {31'd0, bus.stall_out}, 32'd0);
    tick();
    chk("hb_nop1", {31'd0, bus.nop}, 32'd1);
    drive(32'h00500093, 1'b1, 1'b0); tick();
    chk("hb_nop2", {31'd0, bus.nop}, 32'd1);
    tick();
    chk("hb_resume", sel_now(), 32'h10);

    // reset in the middle of a flush
    drive(32'h00500093, 1'b1, 1'b1); tick();
    drive(32'h0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_nop", {31'd0, bus.nop}, 32'd1);
    chk("mid_rst_stall", {31'd0, bus.stall_out}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    drive(32'h123450B7, 1'b1, 1'b0); tick();
    chk("post_rst_capture", sel_now(), 32'h02);
    chk("post_rst_nop", {31'd0, bus.nop}, 32'd0);

    // reset in the middle of a load-use stall
    drive(32'h0000A283, 1'b1, 1'b0); tick();
    drive(32'h00228333, 1'b1, 1'b0); tick();
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    drive(32'h0000A283, 1'b1, 1'b0); tick();
    drive(32'h00228333, 1'b1, 1'b0); #1;
    chk("post_haz_rst_stall", {31'd0, bus.stall_out}, 32'd1);
    tick();
    tick();

    drive(32'h0, 1'b0, 1'b0);
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_decode_stage.md
Name: inst_decode_stage

Overview:
- IF/ID pipeline stage that sits directly upstream of the immediate generator.
- Registers the fetched 32-bit instruction and decodes its opcode into the one-hot immediate-type selects ILoad/S/SB/U/UJ.
- Forwards instruction bits [31:7] as Inst[24:0] and drives nop.
- Inserts bubbles for taken-branch flushes and load-use hazards, and back-pressures fetch via stall_out.

Parameters:
- FLUSH_BUBBLES, 2, number of bubble cycles issued after branch_taken (range 1..7).
- NOP_WORD, 32'h00000013, instruction word loaded into the ID register on reset and on every bubble (addi x0,x0,0).

Ports:
- clk  in  1  processor main clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- inst_in  in  32  instruction word from fetch.
- inst_valid  in  1  inst_in holds a real instruction this cycle.
- branch_taken  in  1  execute stage resolved a taken branch/jump; younger instructions are squashed.
- stall_out  out  1  combinational; fetch must hold PC and inst_in this cycle.
- Inst  out  25  id_inst[31:7], registered; feeds the immediate generator.
- ILoad  out  1  I-type immediate select.
- S  out  1  S-type select.
- SB  out  1  SB-type select.
- U  out  1  U-type select.
- UJ  out  1  UJ-type select.
- nop  out  1  ID slot holds a bubble.
- rs1  out  5  id_inst[19:15].
- rs2  out  5  id_inst[24:20].
- rd  out  5  id_inst[11:7].

Behaviour:
- Internal state: id_inst[31:0], id_valid, FSM state {RUN, HAZ, FLUSH}, bubble counter cnt[2:0].
- Reset (async, asserted rst): id_inst=NOP_WORD, id_valid=0, state=RUN, cnt=0. Outputs under reset: nop=1, all type selects 0, stall_out=0, Inst=NOP_WORD[31:7].
- Decode is combinational from id_inst and gated by id_valid; at most one select is high.
  - ILoad: opcode 0000011, 0010011, 1100111.
  - S: 0100011.
  - SB: 1100011.
  - U: 0110111, 0010111.
  - UJ: 1101111.
  - R-type 0110011 and unknown opcodes: no select, nop=0 if valid.
- nop = ~id_valid.
- Hazard (combinational, evaluated only in RUN): id_valid AND id opcode is LOAD AND rd!=0 AND inst_valid AND one of:
  - inst_in uses rs1 (I, S, SB, R, JALR types) and inst_in[19:15]==rd;
  - inst_in uses rs2 (S, SB, R types) and inst_in[24:20]==rd.
- Transitions, in priority order:
  - RUN, branch_taken: id_inst<=NOP_WORD, id_valid<=0. If FLUSH_BUBBLES>1, cnt<=FLUSH_BUBBLES-1 and go to FLUSH; else stay in RUN.
  - RUN, hazard: stall_out=1, load bubble, go to HAZ.
  - RUN, otherwise: id_inst<=inst_in, id_valid<=inst_valid.
  - HAZ: stall_out=0; capture the held inst_in normally; go to RUN. A branch_taken in HAZ is handled as in RUN, with branch taking priority.
  - FLUSH: load bubble, cnt<=cnt-1; go to RUN when cnt==1. inst_in is ignored. branch_taken in FLUSH reloads cnt=FLUSH_BUBBLES-1.
- Latency: inst_in sampled at edge N appears on Inst and the selects after edge N; the immediate generator then adds its own pipeline delay.
- Simultaneous branch_taken and hazard: branch wins, stall_out=0.
- rst asserted mid-FLUSH or mid-HAZ: immediate return to the reset state; the counter is cleared.

Decomposition:
- Shared package rv_pkg holds:
  - opcode localparams (OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_R);
  - state encodings;
  - NOP_WORD default.
- One natural sub-module: opcode_type_decode, combinational opcode to {ILoad, S, SB, U, UJ, uses_rs1, uses_rs2}. It is instantiated twice: once for id_inst and once for inst_in (hazard use flags).

Test Plan:
- rst pulse, then inst_in=32'h00500093 (addi x1,x0,5) with valid. After one edge: ILoad=1, Inst=25'h00A0_01, rd=1, nop=0.
- Stream sw 32'h00112023, beq 32'h00208463, lui 32'h123450B7, jal 32'h008000EF. Each next cycle gives S, SB, U, UJ respectively, one-hot.
- lw x5,0(x1) 32'h0000A283 followed by add x6,x5,x2 32'h00228333:
  - stall_out=1 for exactly one cycle;
  - one nop cycle;
  - add then appears with no select and rs1=5.
- branch_taken pulse with FLUSH_BUBBLES=2: two consecutive nop=1 cycles, with inst_in ignored, then normal capture resumes.
- lw x0 followed by a use of x0: no stall. Hazard plus branch_taken in the same cycle: stall_out=0, flush taken.
- rst asserted mid-FLUSH: nop=1, state RUN, the next valid instruction is captured on the first edge after release.
